// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and default sizes for the unified MIPS memory.
//   mem_state_t : arbiter/access FSM states
//   grant_t     : which port owns the access in flight
//   DEF_*       : default width/depth used by the top-level parameters
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } mem_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_t;

    localparam int DEF_XLEN        = 32;
    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_WAIT_STATES = 1;

endpackage

// File: rtl/mips_sram_bank.sv
// mips_sram_bank: synchronous single-port word RAM with byte-lane write enables.
//   clk   : clock
//   en    : access strobe; read (and optional write) happens on this edge
//   we    : write enable (qualified by en)
//   addr  : word index
//   wdata : write data
//   be    : byte-lane enables, lane k = wdata[8k+7:8k]
//   rdata : registered read word; a write returns the pre-write contents
// The array is named mem so it can be preloaded hierarchically.
module mips_sram_bank #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [XLEN-1:0]                wdata,
    input  logic [XLEN/8-1:0]              be,
    output logic [XLEN-1:0]                rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                for (int unsigned k = 0; k < XLEN / 8; k++) begin
                    if (be[k]) begin
                        mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mips_unified_mem.sv
// mips_unified_mem: one single-port word memory shared by a fetch port and a
// data port, with req/ack handshakes, wait states, byte writes and range check.
//   clk, rst_n                    : clock, async active-low reset
//   i_req, i_addr                 : fetch request / byte address
//   i_rdata, i_ack, i_err         : fetch result, completion pulse, range error
//   d_req, d_we, d_addr, d_wdata,
//   d_be                          : data request, write flag, address, data, lanes
//   d_rdata, d_ack, d_err         : data result, completion pulse, range error
//   stall                         : a request is outstanding and not yet acked
// Data has fixed priority over fetch. Each access takes WAIT_STATES+2 cycles
// from accept to the next possible accept (ACK is a dead cycle for req drop).
module mips_unified_mem
    import mips_mem_pkg::*;
#(
    parameter int XLEN        = DEF_XLEN,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [XLEN-1:0]   i_addr,
    output logic [XLEN-1:0]   i_rdata,
    output logic              i_ack,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_be,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic              stall
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam int         NB       = XLEN / 8;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    mem_state_t      state;
    grant_t          gnt;
    logic [3:0]      cnt;
    logic            lat_we;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wdata;
    logic [NB-1:0]   lat_be;
    logic [XLEN-1:0] i_hold;
    logic [XLEN-1:0] d_hold;

    // Access-side view: live request in IDLE (needed when WAIT_STATES=0 and
    // the array is hit on the accept edge), latched request otherwise.
    logic            acc_fire;
    logic            acc_is_d;
    logic            acc_we;
    logic [XLEN-1:0] acc_addr;
    logic [XLEN-1:0] acc_wdata;
    logic [NB-1:0]   acc_be;
    logic            acc_ok;
    logic [XLEN-1:0] bank_q;

    always_comb begin
        acc_fire  = 1'b0;
        acc_is_d  = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = '0;
        acc_wdata = '0;
        acc_be    = '0;
        if (state == IDLE) begin
            acc_is_d  = d_req;
            acc_we    = d_req & d_we;
            acc_addr  = d_req ? d_addr : i_addr;
            acc_wdata = d_wdata;
            acc_be    = d_be;
            acc_fire  = (d_req | i_req) && (WAIT_STATES == 0);
        end else begin
            acc_is_d  = (gnt == GNT_D);
            acc_we    = lat_we;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
            acc_be    = lat_be;
            acc_fire  = (state == BUSY) && (cnt == 4'd0);
        end
    end

    assign acc_ok = ((acc_addr >> (IDX_W + 2)) == '0);

    // rst_n gates the strobe so a request held during reset cannot write.
    mips_sram_bank #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .clk   (clk),
        .en    (acc_fire & rst_n),
        .we    (acc_we & acc_ok),
        .addr  (acc_addr[IDX_W+1:2]),
        .wdata (acc_wdata),
        .be    (acc_be),
        .rdata (bank_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= GNT_I;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_err     <= 1'b0;
            d_err     <= 1'b0;
            i_hold    <= '0;
            d_hold    <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            if (acc_fire) begin
                if (acc_is_d) begin
                    d_ack <= 1'b1;
                    d_err <= ~acc_ok;
                end else begin
                    i_ack <= 1'b1;
                    i_err <= ~acc_ok;
                end
            end

            unique case (state)
                IDLE: begin
                    if (d_req | i_req) begin
                        gnt       <= d_req ? GNT_D : GNT_I;
                        lat_we    <= acc_we;
                        lat_addr  <= acc_addr;
                        lat_wdata <= acc_wdata;
                        lat_be    <= acc_be;
                        if (WAIT_STATES == 0) begin
                            state <= ACK;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    if (i_ack) i_hold <= i_rdata;
                    if (d_ack) d_hold <= d_rdata;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The bank's registered read is valid during the ack cycle; afterwards the
    // captured copy keeps rdata stable until the next ack on that port.
    assign i_rdata = i_ack ? (i_err ? '0 : bank_q) : i_hold;
    assign d_rdata = d_ack ? (d_err ? '0 : bank_q) : d_hold;

    assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mips_unified_mem.sv
// Bench for mips_unified_mem (XLEN=32, DEPTH_WORDS=64, WAIT_STATES=2).
// A transaction-level model predicts acks, read data, errors and stall.
module tb_mips_unified_mem;

    localparam int XL = 32;
    localparam int DW = 64;
    localparam int WS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req;
    logic [XL-1:0] i_addr;
    logic [XL-1:0] i_rdata;
    logic          i_ack;
    logic          i_err;
    logic          d_req;
    logic          d_we;
    logic [XL-1:0] d_addr;
    logic [XL-1:0] d_wdata;
    logic [3:0]    d_be;
    logic [XL-1:0] d_rdata;
    logic          d_ack;
    logic          d_err;
    logic          stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_unified_mem #(
        .XLEN        (XL),
        .DEPTH_WORDS (DW),
        .WAIT_STATES (WS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_be    (d_be),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .d_err   (d_err),
        .stall   (stall)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [31:0] rmem [DW];
    int          cyc    = 0;
    bit          m_pend = 0;
    int          m_ackc = 0;
    int          m_free = 0;
    bit          m_d, m_we;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_be;
    bit          e_i_ack = 0, e_d_ack = 0, e_i_err = 0, e_d_err = 0;
    logic [31:0] e_i_rd = '0, e_d_rd = '0;
    bit          m_ok;
    logic [31:0] m_rd;
    logic [5:0]  m_idx;

    task automatic model_clear();
        m_pend  = 0;
        m_free  = 0;
        e_i_ack = 0;
        e_d_ack = 0;
        e_i_err = 0;
        e_d_err = 0;
        e_i_rd  = '0;
        e_d_rd  = '0;
    endtask

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            e_i_ack = 0;
            e_d_ack = 0;
            if (!m_pend && cyc >= m_free && (d_req || i_req)) begin
                m_pend = 1;
                m_d    = d_req;
                m_addr = d_req ? d_addr : i_addr;
                m_we   = d_req && d_we;
                m_wd   = d_wdata;
                m_be   = d_be;
                m_ackc = cyc + WS + 1;
            end
            if (m_pend && cyc + 1 == m_ackc) begin
                m_ok  = (m_addr < 32'(DW * 4));
                m_idx = m_addr[7:2];
                m_rd  = m_ok ? rmem[m_idx] : 32'h0;
                if (m_ok && m_we) begin
                    for (int k = 0; k < 4; k++)
                        if (m_be[k]) rmem[m_idx][8*k +: 8] = m_wd[8*k +: 8];
                end
                if (m_d) begin
                    e_d_ack = 1; e_d_rd = m_rd; e_d_err = !m_ok;
                end else begin
                    e_i_ack = 1; e_i_rd = m_rd; e_i_err = !m_ok;
                end
                m_pend = 0;
                m_free = m_ackc + 1;
            end
        end
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("i_ack", {31'b0, i_ack}, {31'b0, e_i_ack});
        chk("d_ack", {31'b0, d_ack}, {31'b0, e_d_ack});
        chk("stall", {31'b0, stall},
            {31'b0, (i_req & ~e_i_ack) | (d_req & ~e_d_ack)});
        chk("i_rdata", i_rdata, e_i_rd);
        chk("d_rdata", d_rdata, e_d_rd);
        if (e_i_ack) chk("i_err", {31'b0, i_err}, {31'b0, e_i_err});
        if (e_d_ack) chk("d_err", {31'b0, d_err}, {31'b0, e_d_err});
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ack(input bit isd, input int t0, output int lat,
                            output logic [31:0] rd, output logic er);
        bit got = 0;
        lat = -1; rd = 'x; er = 1'bx;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (isd ? d_ack : i_ack) begin
                got = 1;
                lat = cyc - t0;
                rd  = isd ? d_rdata : i_rdata;
                er  = isd ? d_err : i_err;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout actual=none expected=ack port_d=%0d", isd);
        end
    endtask

    task automatic xact(input bit isd, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output int lat, output logic [31:0] rd, output logic er);
        int t0 = cyc;
        if (isd) begin
            d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
        end else begin
            i_req = 1; i_addr = a;
        end
        wait_ack(isd, t0, lat, rd, er);
        @(posedge clk); #1;
        if (isd) d_req = 0; else i_req = 0;
    endtask

    int          lat, lat2, t0, bad;
    logic [31:0] rd, rd2;
    logic        er, er2;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst_n = 0; i_req = 1; d_req = 1; d_we = 0;
        i_addr = 32'h0C; d_addr = 32'h10; d_wdata = '0; d_be = '0;
        for (int i = 0; i < DW; i++) begin
            rmem[i] = 32'hA500_0000 | 32'(i);
            dut.u_bank.mem[i] = 32'hA500_0000 | 32'(i);
        end
        rmem[3] = 32'h2002_0005; dut.u_bank.mem[3] = 32'h2002_0005;
        rmem[4] = 32'h1111_1111; dut.u_bank.mem[4] = 32'h1111_1111;

        // reset with both requests held
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'd1);
        chk("rst_i_ack", {31'b0, i_ack}, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        @(posedge clk); #1;
        i_req = 0; d_req = 0; rst_n = 1;
        @(posedge clk); #1;

        // fetch of word 3
        xact(0, 0, 32'h0C, '0, '0, lat, rd, er);
        chk("fetch_lat", 32'(lat), 32'd3);
        chk("fetch_data", rd, 32'h2002_0005);
        chk("fetch_err", {31'b0, er}, 32'd0);

        // byte-lane write returns pre-write word, then read back merged word
        xact(1, 1, 32'h10, 32'hAABB_CCDD, 4'b0010, lat, rd, er);
        chk("bw_lat", 32'(lat), 32'd3);
        chk("bw_rdata", rd, 32'h1111_1111);
        xact(1, 0, 32'h10, '0, '0, lat, rd, er);
        chk("bw_readback", rd, 32'h1111_CC11);

        // simultaneous requests: data wins, fetch follows
        t0 = cyc;
        d_req = 1; d_we = 0; d_addr = 32'h10;
        i_req = 1; i_addr = 32'h0C;
        wait_ack(1, t0, lat, rd, er);
        @(posedge clk); #1; d_req = 0;
        wait_ack(0, t0, lat2, rd2, er2);
        @(posedge clk); #1; i_req = 0;
        chk("sim_d_lat", 32'(lat), 32'd3);
        chk("sim_i_lat", 32'(lat2), 32'd7);
        chk("sim_i_data", rd2, 32'h2002_0005);

        // out-of-range write
        xact(1, 1, 32'h100, 32'hDEAD_BEEF, 4'hF, lat, rd, er);
        chk("oor_err", {31'b0, er}, 32'd1);
        chk("oor_rdata", rd, 32'h0);
        bad = 0;
        for (int i = 0; i < DW; i++) if (dut.u_bank.mem[i] !== rmem[i]) bad++;
        chk("oor_array", 32'(bad), 32'd0);

        // out-of-range fetch, zero-lane write, full write and readback
        xact(0, 0, 32'hFFFF_FFFC, '0, '0, lat, rd, er);
        chk("oor_fetch_err", {31'b0, er}, 32'd1);
        xact(1, 1, 32'h20, 32'hFFFF_FFFF, 4'h0, lat, rd, er);
        xact(1, 0, 32'h20, '0, '0, lat, rd, er);
        chk("be0_readback", rd, 32'hA500_0008);
        xact(1, 1, 32'hFC, 32'hCAFE_F00D, 4'hF, lat, rd, er);
        xact(0, 0, 32'hFF, '0, '0, lat, rd, er);
        chk("top_word_fetch", rd, 32'hCAFE_F00D);

        // reset during BUSY abandons the write
        d_req = 1; d_we = 1; d_addr = 32'h14; d_wdata = 32'h1234_5678; d_be = 4'hF;
        @(posedge clk); #1;
        rst_n = 0; d_req = 0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1;
        chk("rst_mid_mem5", dut.u_bank.mem[5], 32'hA500_0005);
        xact(1, 1, 32'h14, 32'h1234_5678, 4'hF, lat, rd, er);
        chk("rst_retry_lat", 32'(lat), 32'd3);
        chk("rst_retry_mem5", dut.u_bank.mem[5], 32'h1234_5678);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_unified_mem.md
Name: mips_unified_mem

Overview:
- Parametrised successor to the separate instruction and data memories of the single-cycle core.
- One shared single-port word memory serves an instruction-fetch port and a data port, with req/ack handshakes, configurable wait states, byte-enabled writes and out-of-range detection.
- Target is multi-cycle and stalling MIPS cores: the core holds its request until it sees ack, and uses stall to freeze.

Parameters:
XLEN, 32, data/address width in bits (multiple of 8)
DEPTH_WORDS, 256, memory depth in words (power of two, >=2)
WAIT_STATES, 1, BUSY cycles between accept and ack (0..15)

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held high until i_ack
i_addr  in  XLEN  fetch byte address
i_rdata  out  XLEN  fetched word; valid with i_ack, held until the next i_ack
i_ack  out  1  one-cycle fetch completion pulse
i_err  out  1  fetch address out of range; valid with i_ack
d_req  in  1  data request; held high until d_ack
d_we  in  1  1=write, 0=read
d_addr  in  XLEN  data byte address
d_wdata  in  XLEN  write data
d_be  in  XLEN/8  byte-lane write enables (lane k = bits 8k+7:8k)
d_rdata  out  XLEN  read word (full word, regardless of d_be); valid with d_ack, held until the next d_ack
d_ack  out  1  one-cycle data completion pulse
d_err  out  1  data address out of range; valid with d_ack
stall  out  1  (i_req & ~i_ack) | (d_req & ~d_ack), combinational

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - i_ack, d_ack, i_err, d_err, i_rdata and d_rdata are 0.
  - Memory array is not reset.
  - An access in flight is abandoned: no ack, no write.
- FSM states: IDLE, BUSY, ACK.
  - IDLE:
    - If d_req, grant data; else if i_req, grant fetch. Data has fixed priority.
    - On grant, latch port, we, addr, wdata and be. Go to BUSY, or to ACK directly if WAIT_STATES=0.
  - BUSY:
    - Wait-state counter counts down from WAIT_STATES-1 to 0.
    - At 0, the array access is performed on that edge and the FSM goes to ACK.
  - ACK:
    - Granted port's ack=1 for exactly one cycle; rdata/err registered on entry.
    - Next state is IDLE unconditionally. This dead cycle lets the requester drop req.
- Latency:
  - Accept in cycle t gives ack in cycle t+WAIT_STATES+1.
  - Back-to-back accesses occur every WAIT_STATES+2 cycles.
- Address mapping:
  - Word index = addr[clog2(DEPTH_WORDS)+1:2].
  - addr[1:0] are ignored.
  - Address is out of range if any bit above the index field is nonzero.
- Out-of-range access:
  - err=1 with ack.
  - rdata=0.
  - Write suppressed.
- Writes: only lanes with d_be[k]=1 are updated. d_be=0 gives an ack with no change.
- Read during write: a write access returns the pre-write word on d_rdata.
- Protocol violations (req dropped, or addr/data changed, before ack):
  - The latched request completes unchanged.
  - An ack is still pulsed.
- A request arriving while the FSM is BUSY or ACK waits for IDLE.
- Data priority can starve fetch. By design the core never issues a data request while waiting for a fetch.

Decomposition:
- Package mips_mem_pkg holds:
  - mem_state_t enum {IDLE, BUSY, ACK};
  - grant_t enum {GNT_I, GNT_D};
  - default XLEN and DEPTH constants.
- Sub-module mips_sram_bank:
  - synchronous single-port RAM with byte enables;
  - registered read;
  - array named mem, so benches preload it by backdoor.
- The top holds the arbiter FSM, wait counter, range check and output registers.

Test Plan:
- Reset: hold rst_n=0 with i_req=d_req=1 -> i_ack=d_ack=0, i_rdata=d_rdata=0, stall=1. After release, requests are serviced.
- Fetch (WAIT_STATES=2, DEPTH_WORDS=64): preload mem[3]=0x20020005; i_req, i_addr=0x0C at cycle 0 -> i_ack=1 only in cycle 3, i_rdata=0x20020005, i_err=0.
- Byte write: mem[4]=0x11111111; write d_addr=0x10, d_wdata=0xAABBCCDD, d_be=4'b0010 -> d_ack in cycle 3, d_rdata=0x11111111. A following read of 0x10 returns 0x1111CC11.
- Simultaneous requests at cycle 0: d read 0x10 and i fetch 0x0C -> d_ack in cycle 3; i accepted in cycle 4, i_ack in cycle 7. stall=1 in cycles 0-6.
- Out of range: write d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'hF -> d_ack with d_err=1, d_rdata=0, no array word changed.
- Reset mid-access: write 0x12345678 to 0x14, rst_n=0 during cycle 1 (BUSY) -> no d_ack, mem[5] unchanged. After release, re-issued write acks in 3 cycles and mem[5]=0x12345678.
